receptor_hamming: RTL
=====================

RECEPTOR_HAMMING -- requirements
Module: receptor_hamming

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_bit  in  1  serial code bit.
- in_valid  in  1  in_bit is valid this cycle.
- in_sof  in  1  qualifies in_valid; marks the first bit of a frame.
- in_ready  out  1  block accepts a bit this cycle.
- datos_recibidos  out  7  received word [i3,i2,i1,c2,i0,c1,c0], indices 6..0.
- sindrome  out  3  syndrome [p2,p1,p0].
- out_valid  out  1  datos_recibidos/sindrome are valid.
- out_ready  in  1  downstream corrector consumes the word.
- err_count  out  8  saturating count of words with nonzero syndrome.
- frame_err  out  1  sticky; a frame was aborted by a premature in_sof.

REQ-002 Parameter: none; word width 7 and data width 4 SHALL be fixed package constants.

Function
REQ-003 A bit SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-004 Bits SHALL arrive MSB first: first accepted bit -> index 6 (i3), seventh -> index 0 (c0).
REQ-005 FSM states SHALL be IDLE, RECV and HOLD.
REQ-006 IDLE: in_ready=1; accepted bits with in_sof=0 are discarded. An accepted bit with in_sof=1 stores index 6, sets bit count to 1 and moves to RECV.
REQ-007 RECV: in_ready=1; each accepted bit fills the next index. The seventh bit moves to HOLD on the same edge.
REQ-008 RECV, accepted bit with in_sof=1: abort the partial frame and set frame_err. The bit is treated as index 6 of a new frame; count restarts at 1.
REQ-009 HOLD: in_ready=0, out_valid=1. datos_recibidos and sindrome stay stable until out_ready=1, then return to IDLE on that edge.
REQ-010 Latency: out_valid SHALL assert the cycle after the seventh bit is accepted.
REQ-011 Minimum frame spacing SHALL be one HOLD cycle. A bit offered during HOLD is not accepted (in_ready=0).
REQ-012 Syndrome, with d = datos_recibidos:
- p0 = d0^d2^d4^d6
- p1 = d1^d2^d5^d6
- p2 = d3^d4^d5^d6
The syndrome value equals the 1-based position of a single-bit error; 0 means no error.
REQ-013 sindrome SHALL be registered and valid exactly while out_valid=1.
REQ-014 err_count SHALL increment by 1 on entry to HOLD when the syndrome is nonzero, and saturate at 255.
REQ-015 frame_err SHALL be cleared only by reset.
REQ-016 In RECV, in_valid=0 SHALL leave all state unchanged; there is no timeout.

Reset
REQ-017 On rst_n=0, immediately and independent of clk, all outputs SHALL take these values: state IDLE, bit count 0, datos_recibidos=0, sindrome=0, out_valid=0, err_count=0, frame_err=0, in_ready=1.
REQ-018 Reset asserted mid-frame or in HOLD SHALL discard the frame; no out_valid pulse follows.
REQ-019 The first bit SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-020 Package hamming_pkg SHALL hold:
- N_CODE=7 and K_DATA=4;
- the FSM state enum (IDLE, RECV, HOLD);
- the code-word typedef logic[6:0] and the syndrome typedef logic[2:0].
REQ-021 Syndrome equations SHALL live in one combinational sub-module, calculador_sindrome (7-bit word in, 3-bit syndrome out). The same sub-module is reusable by the corrector's bench.
REQ-022 The shift register, counter and FSM SHALL stay in receptor_hamming.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- Clean word: sof, bits 1010101 (0x55) -> out_valid one cycle after seventh bit; datos_recibidos=0x55, sindrome=000, err_count=0.
- Single error: bits 1000101 (0x45) -> sindrome=101, err_count=1.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, offered bits not accepted; out_ready=1 -> IDLE next cycle.
- Abort: sof plus 3 bits, then sof plus 1010101 -> frame_err=1; output 0x55 with syndrome 000.
- Saturation: 260 words each with one bit flipped -> err_count stops at 255.
- Reset mid-frame: rst_n low after bit 4 -> outputs zero immediately. Next full frame decodes correctly; no spurious out_valid.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(7,4) receive path.
// The word and syndrome types are reused by the downstream corrector.
package hamming_pkg;

    localparam int unsigned N_CODE = 7;
    localparam int unsigned K_DATA = 4;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

    typedef logic [N_CODE-1:0]        code_t;
    typedef logic [N_CODE-K_DATA-1:0] synd_t;

endpackage

// File: rtl/calculador_sindrome.sv
// Combinational Hamming(7,4) syndrome: the result is the 1-based position
// of a single flipped bit, or zero for a clean word.
module calculador_sindrome
    import hamming_pkg::*;
(
    input  code_t palabra_i,
    output synd_t sindrome_o
);

    assign sindrome_o[0] = palabra_i[0] ^ palabra_i[2] ^ palabra_i[4] ^ palabra_i[6];
    assign sindrome_o[1] = palabra_i[1] ^ palabra_i[2] ^ palabra_i[5] ^ palabra_i[6];
    assign sindrome_o[2] = palabra_i[3] ^ palabra_i[4] ^ palabra_i[5] ^ palabra_i[6];

endmodule

// File: rtl/receptor_hamming.sv
// Serial Hamming(7,4) receiver: frames 7 MSB-first bits, holds the word and its
// registered syndrome until the corrector consumes it, and tracks error stats.
module receptor_hamming
    import hamming_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    output logic [6:0] datos_recibidos,
    output logic [2:0] sindrome,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] err_count,
    output logic       frame_err
);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    code_t      word_q, word_d;
    synd_t      synd_q, synd_d;
    logic [7:0] err_q, err_d;
    logic       ferr_q, ferr_d;

    code_t      shift_w;
    synd_t      synd_w;

    // Shifting left places the first accepted bit at index 6 after seven bits.
    assign shift_w = {word_q[5:0], in_bit};

    calculador_sindrome u_sindrome (
        .palabra_i  (shift_w),
        .sindrome_o (synd_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            synd_q  <= '0;
            err_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            synd_q  <= synd_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        synd_d    = synd_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_sof) begin
                    word_d  = shift_w;
                    cnt_d   = 3'd1;
                    state_d = RECV;
                end
            end
            RECV: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d = shift_w;
                    if (in_sof) begin
                        ferr_d = 1'b1;
                        cnt_d  = 3'd1;
                    end else if (cnt_q == 3'd6) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        synd_d  = synd_w;
                        if (synd_w != '0 && err_q != '1) begin
                            err_d = err_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    synd_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign datos_recibidos = word_q;
    assign sindrome        = synd_q;
    assign err_count       = err_q;
    assign frame_err       = ferr_q;

endmodule
